// File: rtl/ibex_vec_pkg.sv
// Shared types, lane map and window packing for the 3x3 vector filter sequencer.
package ibex_vec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } vfs_state_e;

  localparam int LANE_C  = 0;
  localparam int LANE_N  = 1;
  localparam int LANE_W  = 2;
  localparam int LANE_E  = 3;
  localparam int LANE_S  = 4;
  localparam int LANE_NW = 5;
  localparam int LANE_NE = 6;
  localparam int LANE_SW = 7;
  localparam int LANE_SE = 8;

  localparam logic [4:0] VL_SUM_ALL = 5'd0;
  localparam logic [1:0] VSEW_8     = 2'b00;

  function automatic logic [71:0] pack_win(
    input logic [7:0] cen, input logic [7:0] nth, input logic [7:0] wst,
    input logic [7:0] est, input logic [7:0] sth, input logic [7:0] nw,
    input logic [7:0] ne,  input logic [7:0] sw,  input logic [7:0] se
  );
    logic [71:0] w;
    w = '0;
    w[LANE_C*8  +: 8] = cen;
    w[LANE_N*8  +: 8] = nth;
    w[LANE_W*8  +: 8] = wst;
    w[LANE_E*8  +: 8] = est;
    w[LANE_S*8  +: 8] = sth;
    w[LANE_NW*8 +: 8] = nw;
    w[LANE_NE*8 +: 8] = ne;
    w[LANE_SW*8 +: 8] = sw;
    w[LANE_SE*8 +: 8] = se;
    return w;
  endfunction

endpackage

// File: rtl/ibex_vector_line_buf.sv
// One-read/one-write line RAM; read data is registered, so a read and write
// to the same address on one edge returns the previous contents.
module ibex_vector_line_buf #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/ibex_vector_filter_seq.sv
// Streaming sequencer: buffers two lines, builds a 3x3 window per interior
// pixel for the vector filter datapath and returns its results on a stream.
module ibex_vector_filter_seq
  import ibex_vec_pkg::*;
#(
  parameter int MAX_WIDTH = 64,
  parameter int WIDTH_W   = $clog2(MAX_WIDTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [WIDTH_W-1:0] cfg_width_i,
  input  logic [WIDTH_W-1:0] cfg_height_i,
  input  logic               cfg_custom_filt_i,
  input  logic               pix_valid_i,
  output logic               pix_ready_o,
  input  logic [7:0]         pix_data_i,
  output logic [71:0]        win_o,
  output logic               custom_filt_o,
  output logic               mult_en_o,
  output logic               add_en_o,
  output logic               sub_en_o,
  output logic [4:0]         vl_o,
  output logic [1:0]         vsew_o,
  input  logic [7:0]         res_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [7:0]         out_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int ADDR_W = $clog2(MAX_WIDTH);
  localparam logic [WIDTH_W-1:0] W_ONE = WIDTH_W'(1);
  localparam logic [WIDTH_W-1:0] W_TWO = WIDTH_W'(2);
  localparam logic [WIDTH_W-1:0] W_MIN = WIDTH_W'(3);
  localparam logic [WIDTH_W-1:0] W_MAX = WIDTH_W'(MAX_WIDTH);

  vfs_state_e         state_q, state_d;
  logic [WIDTH_W-1:0] width_q, height_q, col_q, row_q, col_nxt;
  logic               custom_q, sel_q, err_q;
  logic               cfg_ok, accept, last_col, last_pix, emit, hs;
  logic [ADDR_W-1:0]  rd_addr;
  logic [7:0]         rd0, rd1, top_rd, mid_rd;
  logic [7:0]         tap_p0 [3][2];
  logic [71:0]        win_nxt, win_p1;
  logic               vld_p1;

  assign cfg_ok   = (cfg_width_i >= W_MIN) && (cfg_width_i <= W_MAX) &&
                    (cfg_height_i >= W_MIN);
  assign pix_ready_o = (state_q == STREAM) && (!vld_p1 || out_ready_i);
  assign accept   = pix_valid_i && pix_ready_o;
  assign hs       = vld_p1 && out_ready_i;
  assign last_col = (col_q == width_q - W_ONE);
  assign last_pix = last_col && (row_q == height_q - W_ONE);
  assign col_nxt  = last_col ? '0 : col_q + W_ONE;
  assign emit     = accept && (row_q >= W_TWO) && (col_q >= W_TWO);

  // Read data is registered, so prefetch the column the next pixel will use.
  assign rd_addr = accept ? col_nxt[ADDR_W-1:0] : col_q[ADDR_W-1:0];

  // sel_q names the buffer holding row r-2; it is overwritten by row r.
  assign top_rd = sel_q ? rd1 : rd0;
  assign mid_rd = sel_q ? rd0 : rd1;

  ibex_vector_line_buf #(.DEPTH(MAX_WIDTH), .ADDR_W(ADDR_W), .DATA_W(8)) u_line_buf0 (
    .clk_i   (clk_i),
    .we_i    (accept && !sel_q),
    .waddr_i (col_q[ADDR_W-1:0]),
    .wdata_i (pix_data_i),
    .raddr_i (rd_addr),
    .rdata_o (rd0)
  );

  ibex_vector_line_buf #(.DEPTH(MAX_WIDTH), .ADDR_W(ADDR_W), .DATA_W(8)) u_line_buf1 (
    .clk_i   (clk_i),
    .we_i    (accept && sel_q),
    .waddr_i (col_q[ADDR_W-1:0]),
    .wdata_i (pix_data_i),
    .raddr_i (rd_addr),
    .rdata_o (rd1)
  );

  // Stage p0: two stored columns plus the incoming column form the window.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int i = 0; i < 3; i++) tap_p0[i][0] <= tap_p0[i][1];
      tap_p0[0][1] <= top_rd;
      tap_p0[1][1] <= mid_rd;
      tap_p0[2][1] <= pix_data_i;
    end
  end

  assign win_nxt = pack_win(
    .cen(tap_p0[1][1]), .nth(tap_p0[0][1]), .wst(tap_p0[1][0]),
    .est(mid_rd),       .sth(tap_p0[2][1]), .nw(tap_p0[0][0]),
    .ne(top_rd),        .sw(tap_p0[2][0]),  .se(pix_data_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      custom_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      sel_q    <= 1'b0;
      err_q    <= 1'b0;
      vld_p1   <= 1'b0;
      win_p1   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && cfg_valid_i && !cfg_ok;
      if ((state_q == IDLE) && cfg_valid_i && cfg_ok) begin
        width_q  <= cfg_width_i;
        height_q <= cfg_height_i;
        custom_q <= cfg_custom_filt_i;
        col_q    <= '0;
        row_q    <= '0;
      end
      if (accept) begin
        col_q <= col_nxt;
        if (last_col) begin
          row_q <= row_q + W_ONE;
          sel_q <= !sel_q;
        end
      end
      // Stage p1: a new window takes priority over retiring the old one.
      if (emit) begin
        vld_p1 <= 1'b1;
        win_p1 <= win_nxt;
      end else if (hs) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cfg_valid_i && cfg_ok) state_d = STREAM;
      end
      STREAM: if (accept && last_pix) state_d = FLUSH;
      FLUSH:  if (hs) state_d = DONE;
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mult_en_o     = busy_o;
  assign add_en_o      = 1'b0;
  assign sub_en_o      = 1'b0;
  assign vl_o          = busy_o ? VL_SUM_ALL : 5'd0;
  assign vsew_o        = busy_o ? VSEW_8 : 2'b00;
  assign custom_filt_o = custom_q;
  assign win_o         = win_p1;
  assign out_valid_o   = vld_p1;
  assign out_data_o    = res_i;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ibex_vector_filter_seq.sv
// Bench for ibex_vector_filter_seq: image-level reference model, datapath stub,
// randomized jobs plus literal pins of window packing and saturation.
module tb_ibex_vector_filter_seq;

  localparam int MAXW = 64;
  localparam int WW   = $clog2(MAXW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_ready, cfg_custom;
  logic [WW-1:0] cfg_width, cfg_height;
  logic          pix_valid, pix_ready;
  logic [7:0]    pix_data;
  logic [71:0]   win;
  logic          custom_filt, mult_en, add_en, sub_en;
  logic [4:0]    vl;
  logic [1:0]    vsew;
  logic [7:0]    res, out_data;
  logic          out_valid, out_ready, busy, done, err;

  always #5 clk = ~clk;

  ibex_vector_filter_seq #(.MAX_WIDTH(MAXW), .WIDTH_W(WW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_width_i(cfg_width), .cfg_height_i(cfg_height), .cfg_custom_filt_i(cfg_custom),
    .pix_valid_i(pix_valid), .pix_ready_o(pix_ready), .pix_data_i(pix_data),
    .win_o(win), .custom_filt_o(custom_filt),
    .mult_en_o(mult_en), .add_en_o(add_en), .sub_en_o(sub_en),
    .vl_o(vl), .vsew_o(vsew), .res_i(res),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  function automatic logic [7:0] sat8(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  // Datapath stub: sharpen kernel when custom, otherwise sum of all nine lanes.
  always_comb begin
    int s;
    s = 0;
    if (custom_filt)
      s = 5 * int'(win[7:0]) - int'(win[15:8]) - int'(win[23:16]) - int'(win[31:24]) - int'(win[39:32]);
    else
      for (int k = 0; k < 9; k++) s += int'(win[8*k +: 8]);
    res = sat8(s);
  end

  int img [64][64];
  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int rdy_mode = 0;
  logic [71:0] exp_win_q[$], got_win[$];
  logic [7:0]  exp_res_q[$], got_res[$];
  int          hs_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm, input int act, input int exp);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: window and result computed directly from the image around (r,c).
  function automatic logic [71:0] win_at(input int r, input int c);
    return {8'(img[r+1][c+1]), 8'(img[r+1][c-1]), 8'(img[r-1][c+1]), 8'(img[r-1][c-1]),
            8'(img[r+1][c]), 8'(img[r][c+1]), 8'(img[r][c-1]), 8'(img[r-1][c]), 8'(img[r][c])};
  endfunction

  function automatic int kern(input int r, input int c, input bit custom);
    int s;
    s = 0;
    if (custom) s = 5 * img[r][c] - img[r-1][c] - img[r][c-1] - img[r][c+1] - img[r+1][c];
    else for (int dr = -1; dr <= 1; dr++) for (int dc = -1; dc <= 1; dc++) s += img[r+dr][c+dc];
    return s;
  endfunction

  // Output monitor: compares every handshake and checks stall stability.
  initial begin
    logic        prev_stall;
    logic [71:0] prev_win;
    prev_stall = 1'b0;
    prev_win   = '0;
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          chk("stall_win_hold", win, prev_win);
          chk("stall_valid_hold", out_valid, 1);
        end
        if (out_valid && !out_ready) chk("stall_pix_ready", pix_ready, 0);
        if (out_valid && out_ready) begin
          got_res.push_back(out_data);
          got_win.push_back(win);
          hs_cyc.push_back(cyc);
          if (exp_res_q.size() == 0) fail_now("extra_output", int'(out_data), -1);
          else begin
            chk("win", win, exp_win_q.pop_front());
            chk("res", out_data, exp_res_q.pop_front());
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_win   = win;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    chk({tag, "_win"}, win, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_custom"}, custom_filt, 0);
    chk({tag, "_ctrl"}, {mult_en, add_en, sub_en, vl, vsew}, 0);
  endtask

  task automatic run_job(input int w, input int h, input bit custom, input int gap_pct,
                         input int abort_after);
    int idx, stall, dc;
    exp_win_q.delete(); exp_res_q.delete();
    got_win.delete(); got_res.delete(); hs_cyc.delete();
    for (int r = 1; r <= h - 2; r++)
      for (int c = 1; c <= w - 2; c++) begin
        exp_win_q.push_back(win_at(r, c));
        exp_res_q.push_back(sat8(kern(r, c, custom)));
      end
    stall = 0;
    @(negedge clk);
    while (!cfg_ready) begin
      if (++stall > 100) begin fail_now("cfg_ready_timeout", 0, 1); return; end
      @(negedge clk);
    end
    cfg_valid = 1; cfg_width = WW'(w); cfg_height = WW'(h); cfg_custom = custom;
    @(negedge clk);
    cfg_valid = 0;
    chk("job_busy", busy, 1);
    chk("job_cfg_ready", cfg_ready, 0);
    chk("job_ctrl", {mult_en, add_en, sub_en, vl, vsew}, {1'b1, 1'b0, 1'b0, 5'd0, 2'b00});
    chk("job_custom", custom_filt, custom);
    idx = 0; stall = 0;
    while (idx < w * h && !(abort_after > 0 && idx >= abort_after)) begin
      @(negedge clk);
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) pix_valid = 0;
      else begin pix_valid = 1; pix_data = 8'(img[idx / w][idx % w]); end
      if (pix_valid && pix_ready) begin idx++; stall = 0; end
      else if (++stall > 200) begin fail_now("pix_accept_timeout", idx, w * h); pix_valid = 0; return; end
    end
    if (abort_after > 0) return;
    @(negedge clk);
    pix_valid = 0;
    chk("flush_pix_ready", pix_ready, 0);
    dc = -1;
    for (int k = 0; k < 2000; k++) begin
      if (done) begin dc = cyc; break; end
      @(negedge clk);
    end
    if (dc < 0) begin fail_now("done_timeout", 0, 1); return; end
    chk("result_count", got_res.size(), (w - 2) * (h - 2));
    chk("expected_left", exp_res_q.size(), 0);
    if (hs_cyc.size() > 0) chk("done_after_last_hs", dc, hs_cyc[hs_cyc.size() - 1] + 1);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
  endtask

  task automatic pin_res(input string nm, input int i, input logic [7:0] exp);
    if (i < got_res.size()) chk(nm, got_res[i], exp);
    else fail_now({nm, "_missing"}, got_res.size(), i + 1);
  endtask

  task automatic pin_win(input string nm, input int i, input logic [71:0] exp);
    if (i < got_win.size()) chk(nm, got_win[i], exp);
    else fail_now({nm, "_missing"}, got_win.size(), i + 1);
  endtask

  task automatic fill(input int w, input int h, input int v);
    for (int r = 0; r < h; r++) for (int c = 0; c < w; c++) img[r][c] = v;
  endtask

  task automatic cfg_err(input int w, input int h);
    @(negedge clk);
    cfg_valid = 1; cfg_width = WW'(w); cfg_height = WW'(h); pix_valid = 1; pix_data = 8'd55;
    @(negedge clk);
    cfg_valid = 0;
    chk("err_pulse", err, 1);
    chk("err_cfg_ready", cfg_ready, 1);
    chk("err_busy", busy, 0);
    chk("err_pix_ready", pix_ready, 0);
    @(negedge clk);
    chk("err_pulse_end", err, 0);
    chk("err_stay_idle", busy, 0);
    pix_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rw, rh;
    rst = 1; cfg_valid = 0; cfg_width = '0; cfg_height = '0; cfg_custom = 0;
    pix_valid = 0; pix_data = '0;
    repeat (3) @(negedge clk);
    check_reset("init");
    @(posedge clk); #1 rst = 0;

    fill(3, 3, 10);
    run_job(3, 3, 1, 0, 0);
    pin_res("all10_res", 0, 8'd10);

    fill(3, 3, 0); img[1][1] = 100;
    run_job(3, 3, 1, 0, 0);
    pin_res("centre_sat_hi", 0, 8'd255);
    pin_win("centre_win", 0, 72'h64);

    fill(3, 3, 0); img[0][1] = 100; img[1][0] = 100; img[1][2] = 100; img[2][1] = 100;
    run_job(3, 3, 1, 0, 0);
    pin_res("cross_sat_lo", 0, 8'd0);
    pin_win("cross_win", 0, 72'h00_00_00_00_64_64_64_64_00);

    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) img[r][c] = 3 * r + c + 1;
    run_job(3, 3, 1, 0, 0);
    pin_win("pack_win", 0, 72'h09_07_03_01_08_06_04_02_05);
    pin_res("pack_res", 0, 8'd5);

    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 16 * r + c;
    rdy_mode = 1;
    run_job(4, 4, 1, 0, 0);
    rdy_mode = 0;
    pin_res("ramp0", 0, 8'd17);
    pin_res("ramp1", 1, 8'd18);
    pin_res("ramp2", 2, 8'd33);
    pin_res("ramp3", 3, 8'd34);

    cfg_err(2, 5);
    cfg_err(MAXW + 1, 5);
    cfg_err(5, 2);

    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = int'($urandom_range(0, 255));
    run_job(8, 8, 1, 0, 20);
    pix_valid = 0;
    rst = 1;
    @(negedge clk);
    check_reset("midjob");
    @(posedge clk); #1 rst = 0;
    exp_win_q.delete(); exp_res_q.delete();
    fill(3, 3, 10);
    run_job(3, 3, 1, 0, 0);
    pin_res("after_reset_res", 0, 8'd10);

    for (int r = 0; r < 3; r++) for (int c = 0; c < 5; c++) img[r][c] = int'($urandom_range(0, 255));
    run_job(5, 3, 1, 0, 0);
    if (hs_cyc.size() == 3) begin
      chk("no_bubble_a", hs_cyc[1] - hs_cyc[0], 1);
      chk("no_bubble_b", hs_cyc[2] - hs_cyc[1], 1);
    end else fail_now("b2b_5x3_count", hs_cyc.size(), 3);
    for (int r = 0; r < 5; r++) for (int c = 0; c < 3; c++) img[r][c] = int'($urandom_range(0, 255));
    run_job(3, 5, 1, 0, 0);

    rdy_mode = 2;
    for (int j = 0; j < 5; j++) begin
      rw = int'($urandom_range(3, 12));
      rh = int'($urandom_range(3, 7));
      for (int r = 0; r < rh; r++) for (int c = 0; c < rw; c++) img[r][c] = int'($urandom_range(0, 255));
      run_job(rw, rh, 1'($urandom_range(0, 1)), 30, 0);
    end
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
